// File: rtl/wb_master_arbiter_if.sv
// wb_master_arbiter_if: bundle of the two Wishbone master ports and the shared slave port
interface wb_master_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          m0_cyc_i, m0_stb_i, m0_we_i, m0_ack_o;
  logic [DW/8-1:0] m0_sel_i;
  logic [AW-1:0] m0_addr_i;
  logic [DW-1:0] m0_data_i, m0_data_o;
  logic          m1_cyc_i, m1_stb_i, m1_we_i, m1_ack_o;
  logic [DW/8-1:0] m1_sel_i;
  logic [AW-1:0] m1_addr_i;
  logic [DW-1:0] m1_data_i, m1_data_o;
  logic          s_cyc_o, s_stb_o, s_we_o, s_ack_i;
  logic [DW/8-1:0] s_sel_o;
  logic [AW-1:0] s_addr_o;
  logic [DW-1:0] s_data_o, s_data_i;
  // arbiter view: it is the slave of both masters and drives the shared slave port
  modport slave (
    input  m0_cyc_i, m0_stb_i, m0_we_i, m0_sel_i, m0_addr_i, m0_data_i,
    output m0_ack_o, m0_data_o,
    input  m1_cyc_i, m1_stb_i, m1_we_i, m1_sel_i, m1_addr_i, m1_data_i,
    output m1_ack_o, m1_data_o,
    output s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_addr_o, s_data_o,
    input  s_ack_i, s_data_i
  );
  // environment view: drives both masters and models the slave
  modport master (
    output m0_cyc_i, m0_stb_i, m0_we_i, m0_sel_i, m0_addr_i, m0_data_i,
    input  m0_ack_o, m0_data_o,
    output m1_cyc_i, m1_stb_i, m1_we_i, m1_sel_i, m1_addr_i, m1_data_i,
    input  m1_ack_o, m1_data_o,
    input  s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_addr_o, s_data_o,
    output s_ack_i, s_data_i
  );
endinterface

// File: rtl/wb_master_arbiter.sv
// wb_master_arbiter: two-master round-robin Wishbone arbiter; grant held for a whole cyc; optional stall timeout via WB_ARB_TIMEOUT_EN
module wb_master_arbiter #(
  parameter int AW             = 32,
  parameter int DW             = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                wb_clock_i,
  input  logic                wb_reset_i,
  wb_master_arbiter_if.slave  bus,
  output logic [1:0]          grant_o,
  output logic                timeout_o
);
  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;
  state_t        state_q, state_d;
  logic          last_q, last_d;
  logic          req0, req1, own0, own1, own_cyc, own_stb, fire;
  logic [AW-1:0] addr_mux;
  logic [DW-1:0] to_data;
  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must lie in 2..255");
  end
  assign req0     = bus.m0_cyc_i & bus.m0_stb_i;
  assign req1     = bus.m1_cyc_i & bus.m1_stb_i;
  assign own0     = state_q == OWN0;
  assign own1     = state_q == OWN1;
  assign own_cyc  = own0 ? bus.m0_cyc_i : own1 ? bus.m1_cyc_i : 1'b0;
  assign own_stb  = own0 ? bus.m0_stb_i : own1 ? bus.m1_stb_i : 1'b0;
  assign addr_mux = own0 ? bus.m0_addr_i : own1 ? bus.m1_addr_i : '0;
  assign to_data  = DW'(32'hDEAD_BEEF);
  // arbitration in IDLE (tie goes to the master that did not own last); release when the owner drops cyc
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    if (state_q == IDLE)
      state_d = (req0 & req1) ? (last_q ? OWN0 : OWN1) : req0 ? OWN0 : req1 ? OWN1 : IDLE;
    else if (!own_cyc) begin
      state_d = IDLE;
      last_d  = own1;
    end
  end
  // owner register; last_owner resets to 1 so master 0 wins the first tie
  always_ff @(posedge wb_clock_i or posedge wb_reset_i)
    if (wb_reset_i) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
`ifdef WB_ARB_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;
  assign fire = own_stb & ~bus.s_ack_i & (cnt_q == 8'(TIMEOUT_CYCLES - 1));
  // stall counter: cleared while idle (so fresh on grant), on any slave ack and on a forced termination
  always_comb cnt_d = (state_q == IDLE || fire || bus.s_ack_i) ? 8'd0 : own_stb ? cnt_q + 8'd1 : cnt_q;
  // stall counter register
  always_ff @(posedge wb_clock_i or posedge wb_reset_i)
    if (wb_reset_i) cnt_q <= 8'd0;
    else            cnt_q <= cnt_d;
`else
  assign fire = 1'b0;
`endif
  assign bus.s_cyc_o   = own_cyc;
  assign bus.s_stb_o   = own_stb & ~fire;
  assign bus.s_we_o    = own0 ? bus.m0_we_i : own1 ? bus.m1_we_i : 1'b0;
  assign bus.s_sel_o   = own0 ? bus.m0_sel_i : own1 ? bus.m1_sel_i : '0;
  assign bus.s_addr_o  = addr_mux;
  assign bus.s_data_o  = own0 ? bus.m0_data_i : own1 ? bus.m1_data_i : '0;
  assign bus.m0_ack_o  = own0 & bus.m0_stb_i & (bus.s_ack_i | fire);
  assign bus.m1_ack_o  = own1 & bus.m1_stb_i & (bus.s_ack_i | fire);
  assign bus.m0_data_o = !own0 ? '0 : fire ? to_data : bus.s_data_i;
  assign bus.m1_data_o = !own1 ? '0 : fire ? to_data : bus.s_data_i;
  assign grant_o       = {own1, own0};
  assign timeout_o     = fire;
endmodule
